// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game front-end controller.
// Holds the 2-bit FSM state encoding.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/game_ctrl_fsm_btn_debounce.sv
// One button channel: 2-flop synchroniser, run-length debouncer,
// registered stable level and one-cycle rising press pulse.
module btn_debounce #(
  parameter int HOLD_CYCLES = 30000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      // cnt tracks how long the synced level has disagreed
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CMAX) begin
        stable_q <= s2_q;
        press_q  <= s2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game front-end: debounced buttons plus IDLE/RUN/PAUSE/OVER FSM
// with speed latching while idle.
module game_ctrl_fsm
  import game_ctrl_pkg::*;
#(
  parameter int                 NUM_BTN     = 3,
  parameter int                 HOLD_CYCLES = 30000,
  parameter int                 SPEED_W     = 3,
  parameter logic [NUM_BTN-1:0] START_MASK  = {NUM_BTN{1'b1}},
  parameter int                 RESET_BTN   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [SPEED_W-1:0] speed,
  input  logic               stop,
  input  logic               game_over,
  output logic [NUM_BTN-1:0] btn_stable,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [SPEED_W-1:0] speed_out,
  output logic               speed_enable,
  output logic               run_active,
  output logic [1:0]         state
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .stable(btn_stable[i]),
      .press (btn_press[i])
    );
  end

  state_e             state_q;
  logic [SPEED_W-1:0] speed_q;
  logic               en_q;
  logic               run_q;
  logic               rbtn;

  assign rbtn = btn_press[RESET_BTN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      speed_q <= '0;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          speed_q <= speed;
          if (btn_stable == START_MASK) begin
            state_q <= ST_RUN;
            en_q    <= 1'b1;
            run_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            state_q <= ST_OVER;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
          end else if (stop) begin
            state_q <= ST_PAUSE;
            run_q   <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (game_over) begin
            state_q <= ST_OVER;
            en_q    <= 1'b0;
          end else if (!stop) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end else if (rbtn) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
          end
        end
        ST_OVER: begin
          if (rbtn) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign speed_out    = speed_q;
  assign speed_enable = en_q;
  assign run_active   = run_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed and random stimulus for game_ctrl_fsm, checked each cycle
// against a behavioural model of buttons and game flow.
module tb_game_ctrl_fsm;

  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] speed;
  logic       stop;
  logic       game_over;
  logic [2:0] btn_stable;
  logic [2:0] btn_press;
  logic [2:0] speed_out;
  logic       speed_enable;
  logic       run_active;
  logic [1:0] state;

  game_ctrl_fsm #(
    .NUM_BTN    (3),
    .HOLD_CYCLES(H),
    .SPEED_W    (3),
    .START_MASK (3'b111),
    .RESET_BTN  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .speed       (speed),
    .stop        (stop),
    .game_over   (game_over),
    .btn_stable  (btn_stable),
    .btn_press   (btn_press),
    .speed_out   (speed_out),
    .speed_enable(speed_enable),
    .run_active  (run_active),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: pad samples pipeline, stable level, run length of disagreement
  int m_p1[3];
  int m_p2[3];
  int m_st[3];
  int m_run[3];
  int m_pr[3];
  int m_state;
  int m_spd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    int all_on;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_p1[i] = 0; m_p2[i] = 0; m_st[i] = 0;
        m_run[i] = 0; m_pr[i] = 0;
      end
      m_state = 0;
      m_spd   = 0;
      return;
    end
    all_on = (m_st[0] == 1 && m_st[1] == 1 && m_st[2] == 1) ? 1 : 0;
    case (m_state)
      0: begin
        m_spd = int'(speed);
        if (all_on == 1) m_state = 1;
      end
      1: begin
        if (game_over) m_state = 3;
        else if (stop) m_state = 2;
      end
      2: begin
        if (game_over) m_state = 3;
        else if (!stop) m_state = 1;
        else if (m_pr[0] == 1) m_state = 0;
      end
      default: if (m_pr[0] == 1) m_state = 0;
    endcase
    for (int i = 0; i < 3; i++) begin
      m_pr[i] = 0;
      if (m_p2[i] != m_st[i]) begin
        m_run[i]++;
        if (m_run[i] == H) begin
          m_st[i]  = m_p2[i];
          m_pr[i]  = m_p2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_p2[i] = m_p1[i];
      m_p1[i] = int'(btn_raw[i]);
    end
  endtask

  task automatic step();
    logic [2:0] es;
    logic [2:0] ep;
    @(posedge clk);
    model();
    #1;
    for (int i = 0; i < 3; i++) begin
      es[i] = (m_st[i] != 0);
      ep[i] = (m_pr[i] != 0);
    end
    chk("stable", 32'(btn_stable), 32'(es));
    chk("press", 32'(btn_press), 32'(ep));
    chk("state", 32'(state), 32'(m_state));
    chk("speed_out", 32'(speed_out), 32'(m_spd));
    chk("speed_en", 32'(speed_enable),
        (m_state == 1 || m_state == 2) ? 32'd1 : 32'd0);
    chk("run_act", 32'(run_active), (m_state == 1) ? 32'd1 : 32'd0);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; btn_raw = '0; speed = '0; stop = 1'b0; game_over = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_p1[i] = 0; m_p2[i] = 0; m_st[i] = 0; m_run[i] = 0; m_pr[i] = 0;
    end
    m_state = 0; m_spd = 0;
    steps(2);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b0;

    // short glitch is rejected
    btn_raw = 3'b001;
    steps(3);
    btn_raw = 3'b000;
    steps(8);
    chk("t1_stable", 32'(btn_stable), 32'd0);

    // all buttons start a game with speed 5
    speed = 3'd5;
    btn_raw = 3'b111;
    steps(6);
    chk("t2_stable", 32'(btn_stable), 32'd7);
    chk("t2_press", 32'(btn_press), 32'd7);
    step();
    chk("t2_state", 32'(state), 32'd1);
    chk("t2_spd", 32'(speed_out), 32'd5);
    speed = 3'd2;
    steps(3);
    chk("t2_frozen", 32'(speed_out), 32'd5);

    // pause, resume, pause then reset button
    stop = 1'b1;
    step();
    chk("t3_pause", 32'(state), 32'd2);
    stop = 1'b0;
    step();
    chk("t3_resume", 32'(state), 32'd1);
    stop = 1'b1;
    step();
    btn_raw = 3'b110;
    steps(8);
    btn_raw = 3'b111;
    steps(7);
    chk("t3_idle", 32'(state), 32'd0);
    chk("t3_en", 32'(speed_enable), 32'd0);
    stop = 1'b0;
    step();

    // game over beats stop
    game_over = 1'b1; stop = 1'b1;
    step();
    chk("t4_over", 32'(state), 32'd3);
    game_over = 1'b0; stop = 1'b0;
    btn_raw = 3'b110;
    steps(8);
    btn_raw = 3'b111;
    steps(7);
    chk("t4_idle", 32'(state), 32'd0);
    step();

    // reset mid-game with buttons held
    rst = 1'b1;
    step();
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_stable", 32'(btn_stable), 32'd0);
    rst = 1'b0;
    steps(6);
    chk("t5_requal", 32'(btn_stable), 32'd7);
    step();
    chk("t5_run", 32'(state), 32'd1);

    // fast toggling never accepted
    for (int k = 0; k < 50; k++) begin
      if (k % 2 == 0) btn_raw[1] = ~btn_raw[1];
      step();
      chk("t6_hold", 32'(btn_stable[1]), 32'd1);
    end
    btn_raw = 3'b111;

    // random traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(0, 3) == 0) speed = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) stop = ~stop;
      game_over = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
